// File: rtl/bin_frame_grabber_pkg.sv
// bfg_pkg: shared types and helpers for the binarising frame grabber.
//   state_t      - capture FSM state encoding (also the oSTATE/LEDR encoding)
//   MODE_*       - channel-combine modes selected by iMODE
//   ceil_div     - integer ceiling divide, used for words per line
//   clog2_min1   - address width that never collapses to zero bits
package bfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [1:0] MODE_CH0 = 2'd0;
    localparam logic [1:0] MODE_AND = 2'd1;
    localparam logic [1:0] MODE_OR  = 2'd2;
    localparam logic [1:0] MODE_INV = 2'd3;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/bin_frame_grabber_if.sv
// bfg_rd_if: HPS random-access read port of the binary frame store.
//   iRD_REQ   - one-cycle read request (master -> slave)
//   iRD_ROW   - pixel row address
//   iRD_COL   - pixel column address
//   oRD_BIT   - pixel value returned (slave -> master)
//   oRD_VALID - one-cycle response strobe, two cycles after the request
//   oRD_ERR   - response error flag, qualified by oRD_VALID
interface bfg_rd_if #(
    parameter int ROW_W = 9,
    parameter int COL_W = 10
);
    logic             iRD_REQ;
    logic [ROW_W-1:0] iRD_ROW;
    logic [COL_W-1:0] iRD_COL;
    logic             oRD_BIT;
    logic             oRD_VALID;
    logic             oRD_ERR;

    modport master (
        output iRD_REQ, iRD_ROW, iRD_COL,
        input  oRD_BIT, oRD_VALID, oRD_ERR
    );

    modport slave (
        input  iRD_REQ, iRD_ROW, iRD_COL,
        output oRD_BIT, oRD_VALID, oRD_ERR
    );
endinterface

// File: rtl/bin_frame_grabber_sdp_ram.sv
// bfg_sdp_ram: simple dual-port RAM, one write port and one registered
// read port with single-cycle latency. No reset on the array or read
// register so the block maps onto an M10K.
//   i_clk   - clock
//   i_we    - write enable
//   i_waddr - write address
//   i_wdata - write data
//   i_raddr - read address
//   o_rdata - read data, valid the cycle after i_raddr
module bfg_sdp_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32,
    parameter int AW    = 10
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_q <= r_mem[i_raddr];
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/bin_frame_grabber.sv
// bin_frame_grabber: thresholds each valid pixel of the RAW2RGB stream,
// packs the binary result PACK_W pixels per word into on-chip RAM and
// lets the HPS read any pixel back by row/column once a frame is done.
//   iCLK, iRST - pixel clock, asynchronous active-high reset
//   iDATA      - NUM_CH channels of DATA_W bits, channel k at [k*DATA_W +: DATA_W]
//   iDVAL      - iDATA valid
//   iSOF       - frame-start pulse
//   iTHRESH    - per-channel thresholds, same packing as iDATA
//   iMODE      - channel combine: 0=ch0, 1=AND, 2=OR, 3=NOT ch0
//   iSTART     - HPS capture-start level
//   rd         - read port (bfg_rd_if.slave)
//   oSTATE     - FSM state, 0=IDLE 1=ARMED 2=CAPTURE 3=DONE
//   oDONE      - frame complete
//   oFG_CNT    - foreground pixel count of the last frame
// Build option: define BIN_FRAME_GRABBER_STATS_EN to build the foreground
// counter; otherwise oFG_CNT is tied to 0.
//
// state   | meaning
// IDLE    | waiting for a rising edge of iSTART
// ARMED   | waiting for iSOF
// CAPTURE | storing pixels of the current frame
// DONE    | frame stored, reads allowed, waiting for the next iSTART edge
module bin_frame_grabber
    import bfg_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int DATA_W = 12,
    parameter int NUM_CH = 3,
    parameter int PACK_W = 32
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic [NUM_CH*DATA_W-1:0] iDATA,
    input  logic                     iDVAL,
    input  logic                     iSOF,
    input  logic [NUM_CH*DATA_W-1:0] iTHRESH,
    input  logic [1:0]               iMODE,
    input  logic                     iSTART,
    bfg_rd_if.slave                  rd,
    output logic [1:0]               oSTATE,
    output logic                     oDONE,
    output logic [31:0]              oFG_CNT
);

    localparam int WPL   = ceil_div(IMG_W, PACK_W);
    localparam int DEPTH = IMG_H * WPL;
    localparam int AW    = clog2_min1(DEPTH);
    localparam int ROW_W = clog2_min1(IMG_H);
    localparam int COL_W = clog2_min1(IMG_W);
    localparam int PW    = clog2_min1(PACK_W);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [PW-1:0]    POS_LAST = PW'(PACK_W - 1);

    state_t              r_state;
    state_t              w_next;
    logic                r_start_d;
    logic [1:0]          r_mode;
    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;
    logic [PW-1:0]       r_pos;
    logic [AW-1:0]       r_addr;
    logic [PACK_W-1:0]   r_pack;
    logic                r_done;

    logic                w_start_rise;
    logic                w_arm;
    logic                w_sof_take;
    logic                w_px;
    logic [COL_W-1:0]    w_col;
    logic [ROW_W-1:0]    w_row;
    logic [PW-1:0]       w_pos;
    logic [AW-1:0]       w_addr;
    logic [PACK_W-1:0]   w_pack_base;
    logic [1:0]          w_mode;
    logic [NUM_CH-1:0]   w_ch_hit;
    logic                w_bit;
    logic [PACK_W-1:0]   w_word;
    logic                w_eol;
    logic                w_flush;
    logic                w_last;

    assign w_start_rise = iSTART & ~r_start_d;

    // An SOF accepted in ARMED or CAPTURE restarts the frame; a pixel
    // coincident with it is treated as pixel (0,0) of the new frame.
    assign w_sof_take = iSTART && iSOF &&
                        (r_state == ST_ARMED || r_state == ST_CAPTURE);
    assign w_px       = iSTART && iDVAL &&
                        (r_state == ST_CAPTURE || (r_state == ST_ARMED && iSOF));

    assign w_col       = w_sof_take ? '0 : r_col;
    assign w_row       = w_sof_take ? '0 : r_row;
    assign w_pos       = w_sof_take ? '0 : r_pos;
    assign w_addr      = w_sof_take ? '0 : r_addr;
    assign w_pack_base = w_sof_take ? '0 : r_pack;
    assign w_mode      = w_sof_take ? iMODE : r_mode;

    always_comb begin
        w_ch_hit = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_ch_hit[k] = iDATA[k*DATA_W +: DATA_W] > iTHRESH[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        w_bit = 1'b0;
        case (w_mode)
            MODE_CH0: w_bit = w_ch_hit[0];
            MODE_AND: w_bit = &w_ch_hit;
            MODE_OR:  w_bit = |w_ch_hit;
            MODE_INV: w_bit = ~w_ch_hit[0];
            default:  w_bit = 1'b0;
        endcase
    end

    // Unwritten positions stay zero, which pads the last word of a line.
    assign w_word  = w_pack_base | (PACK_W'(w_bit) << w_pos);
    assign w_eol   = (w_col == COL_LAST);
    assign w_flush = w_px && (w_pos == POS_LAST || w_eol);
    assign w_last  = w_px && w_eol && (w_row == ROW_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_arm) w_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (!iSTART)         w_next = ST_IDLE;
                else if (w_sof_take) w_next = w_last ? ST_DONE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (!iSTART)     w_next = ST_IDLE;
                else if (w_last) w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        oSTATE = r_state;
        w_arm  = w_start_rise && (r_state == ST_IDLE || r_state == ST_DONE);
    end

    // ---------------- capture datapath ----------------
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_start_d <= 1'b0;
            r_mode    <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_pos     <= '0;
            r_addr    <= '0;
            r_pack    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_start_d <= iSTART;
            if (w_sof_take) begin
                r_mode <= iMODE;
            end
            if (w_px) begin
                if (w_eol) begin
                    r_col <= '0;
                    r_row <= (w_row == ROW_LAST) ? '0 : w_row + ROW_W'(1);
                end else begin
                    r_col <= w_col + COL_W'(1);
                    r_row <= w_row;
                end
                // Lines are stored back to back, so the word address
                // simply advances by one per word written.
                if (w_flush) begin
                    r_pack <= '0;
                    r_pos  <= '0;
                    r_addr <= w_last ? '0 : w_addr + AW'(1);
                end else begin
                    r_pack <= w_word;
                    r_pos  <= w_pos + PW'(1);
                    r_addr <= w_addr;
                end
            end else if (w_sof_take) begin
                r_col  <= '0;
                r_row  <= '0;
                r_pos  <= '0;
                r_addr <= '0;
                r_pack <= '0;
            end
            if (w_arm) begin
                r_done <= 1'b0;
            end else if (w_last) begin
                r_done <= 1'b1;
            end
        end
    end

    assign oDONE = r_done;

`ifdef BIN_FRAME_GRABBER_STATS_EN
    logic [31:0] r_fg;
    logic [31:0] w_fg_base;

    assign w_fg_base = w_sof_take ? 32'd0 : r_fg;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_fg <= '0;
        end else if (w_arm) begin
            r_fg <= '0;
        end else if (w_px && w_bit) begin
            r_fg <= (&w_fg_base) ? w_fg_base : w_fg_base + 32'd1;
        end else if (w_sof_take) begin
            r_fg <= '0;
        end
    end

    assign oFG_CNT = r_fg;
`else
    assign oFG_CNT = '0;
`endif

    // ---------------- frame store ----------------
    logic [AW-1:0]     w_rd_addr;
    logic [PACK_W-1:0] w_rd_q;
    logic              w_rd_oob;
    logic              w_rd_bad;
    logic [PW-1:0]     w_rd_pos;

    bfg_sdp_ram #(
        .DEPTH (DEPTH),
        .WIDTH (PACK_W),
        .AW    (AW)
    ) u_ram (
        .i_clk   (iCLK),
        .i_we    (w_flush),
        .i_waddr (w_addr),
        .i_wdata (w_word),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_q)
    );

    // ---------------- read pipeline ----------------
    logic          r_rd_v1;
    logic          r_rd_bad1;
    logic [PW-1:0] r_rd_pos1;
    logic          r_rd_valid;
    logic          r_rd_err;
    logic          r_rd_bit;

    assign w_rd_oob  = (int'(rd.iRD_ROW) >= IMG_H) || (int'(rd.iRD_COL) >= IMG_W);
    assign w_rd_bad  = w_rd_oob || (r_state != ST_DONE);
    // Out-of-range addresses are parked at word 0 so the RAM index stays legal.
    assign w_rd_addr = w_rd_oob ? '0 :
                       AW'(int'(rd.iRD_ROW) * WPL + int'(rd.iRD_COL) / PACK_W);
    assign w_rd_pos  = PW'(int'(rd.iRD_COL) % PACK_W);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_rd_v1    <= 1'b0;
            r_rd_bad1  <= 1'b0;
            r_rd_pos1  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_rd_bit   <= 1'b0;
        end else begin
            r_rd_v1    <= rd.iRD_REQ;
            r_rd_bad1  <= w_rd_bad;
            r_rd_pos1  <= w_rd_pos;
            r_rd_valid <= r_rd_v1;
            r_rd_err   <= r_rd_v1 && r_rd_bad1;
            r_rd_bit   <= r_rd_v1 && !r_rd_bad1 && w_rd_q[r_rd_pos1];
        end
    end

    assign rd.oRD_VALID = r_rd_valid;
    assign rd.oRD_ERR   = r_rd_err;
    assign rd.oRD_BIT   = r_rd_bit;

endmodule

// File: doc/bin_frame_grabber.md
Name: bin_frame_grabber

Overview:
- Multi-channel binarising frame grabber between the RAW2RGB pixel stream and the HPS PIO interface.
- Thresholds each valid pixel with a selectable channel-combine mode and packs the binary pixels PACK_W per word into on-chip RAM.
- Under a start/done handshake, the HPS reads any pixel back by row/column address.
- Replaces the single-bit SDRAM path with a fixed-latency, random-access binary frame store.

Parameters:
- IMG_W, 640, active pixels per line
- IMG_H, 480, active lines per frame
- DATA_W, 12, bits per colour channel
- NUM_CH, 3, colour channels per pixel (1..4)
- PACK_W, 32, binary pixels per RAM word

Ports:
- iCLK  in  1  pixel clock; all logic on rising edge
- iRST  in  1  asynchronous, active-high reset
- iDATA  in  NUM_CH*DATA_W  pixel; channel k at bits [k*DATA_W +: DATA_W]
- iDVAL  in  1  iDATA valid this cycle
- iSOF  in  1  one-cycle frame-start pulse, coincident with or before first valid pixel
- iTHRESH  in  NUM_CH*DATA_W  per-channel thresholds
- iMODE  in  2  0=ch0, 1=AND all, 2=OR all, 3=NOT ch0
- iSTART  in  1  HPS capture-start level
- iRD_REQ  in  1  one-cycle read request
- iRD_ROW  in  clog2(IMG_H)  read row
- iRD_COL  in  clog2(IMG_W)  read column
- oRD_BIT  out  1  read pixel
- oRD_VALID  out  1  one-cycle read response strobe
- oRD_ERR  out  1  response error flag, qualified by oRD_VALID
- oSTATE  out  2  0=IDLE, 1=ARMED, 2=CAPTURE, 3=DONE; drives LEDR
- oDONE  out  1  frame complete
- oFG_CNT  out  32  foreground pixel count of the last frame

Behaviour:
- Reset values: state IDLE; all outputs 0; column/row counters, pack register and iSTART edge register cleared. RAM contents are undefined.
- Channel bit k = (channel k > iTHRESH k), unsigned strict compare. The pixel bit combines these per iMODE.
- iMODE is latched on the SOF that enters CAPTURE and held for the whole frame.
- IDLE or DONE: a rising edge of iSTART (registered compare) -> ARMED. oDONE clears and oFG_CNT clears.
- ARMED: iSOF -> CAPTURE; column and row counters set to 0.
- CAPTURE, each iDVAL:
  - Shift the pixel bit into the pack register; column 0 of each word lands in bit 0 (LSB-first).
  - Write the word to RAM when PACK_W bits have accumulated or the column equals IMG_W-1. A partial last word is zero-padded.
  - Word address = row*WPL + col/PACK_W, where WPL = ceil(IMG_W/PACK_W).
  - The column wraps at IMG_W and increments the row.
- Last pixel (row IMG_H-1, column IMG_W-1) -> DONE. oDONE asserts on the cycle after that pixel's RAM write.
- iSOF during CAPTURE: restart at row 0/column 0. The partial word is discarded and oFG_CNT is cleared.
- iSTART low in ARMED or CAPTURE: abort to IDLE. oDONE stays 0.
- iSTART edges while ARMED or CAPTURE are ignored.
- iDVAL outside CAPTURE is ignored. Pixels arriving in DONE never overwrite the frame.
- Reads:
  - iRD_REQ is sampled in any state; address and state are captured.
  - oRD_VALID pulses exactly 2 cycles later: 1 cycle RAM read, 1 cycle bit select.
  - oRD_ERR=1 and oRD_BIT=0 if the state was not DONE or the row/column is out of range.
  - Back-to-back requests every cycle are supported and pipelined.
- oFG_CNT increments per foreground pixel written and saturates at 2^32-1.
- A write and a read to the same word in the same cycle are impossible, because reads succeed only in DONE.
- Reset mid-capture returns to IDLE immediately.

Optional Feature:
- Macro: BIN_FRAME_GRABBER_STATS_EN.
- Defined: oFG_CNT counts as above.
- Undefined: the counter is not built and oFG_CNT is tied to 0.

Decomposition:
- Package bfg_pkg holds:
  - state enum (IDLE/ARMED/CAPTURE/DONE)
  - mode constants (MODE_CH0, MODE_AND, MODE_OR, MODE_INV)
  - ceil-divide function for WPL
- Sub-module bfg_sdp_ram: simple dual-port RAM, depth IMG_H*WPL, width PACK_W, one write port, registered read with 1-cycle latency; infers M10K.

Test Plan (IMG_W=8, IMG_H=4, NUM_CH=3, DATA_W=12, PACK_W=4 unless noted):
- Reset, then read (0,0) -> oRD_VALID 2 cycles later with oRD_ERR=1, oRD_BIT=0; oSTATE=0.
- iSTART 0->1, SOF, 32 pixels with ch0 = col*100, thresh0=350, MODE=0 -> DONE. Reads of row 2, cols 3/4 -> 0/1. oFG_CNT=16.
- MODE=1, ch1 below threshold only at (1,5) -> (1,5) reads 0. MODE=2, all channels below threshold except ch2 at (3,7) -> only (3,7) reads 1.
- IMG_W=6: line padding places row 1 at word address 2. Read (1,5) correct; read col 6 -> oRD_ERR=1.
- iSTART dropped after 10 pixels -> IDLE, oDONE=0. Second SOF mid-frame -> restart; count reflects the second frame only.
- With the macro undefined -> oFG_CNT stays 0. 4 consecutive iRD_REQ -> 4 consecutive oRD_VALID strobes in order.
